// File: rtl/acl_spi_reader_if.sv
// SPI pin bundle between acl_spi_reader (master) and the accelerometer (slave).
interface acl_spi_reader_if;
  logic acl_sclk;
  logic acl_mosi;
  logic acl_miso;
  logic acl_cs_n;

  modport master (
    output acl_sclk,
    output acl_mosi,
    output acl_cs_n,
    input  acl_miso
  );

  modport slave (
    input  acl_sclk,
    input  acl_mosi,
    input  acl_cs_n,
    output acl_miso
  );
endinterface

// File: rtl/acl_spi_reader.sv
// SPI mode-3 master: powers up the accelerometer, then polls one axis into a 10-bit word.
// Optional ACL_AVG_EN: acl_out becomes the running mean of the last four raw samples.
module acl_spi_reader #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  AXIS_REG      = 8'h34
) (
  input  logic                    clk,
  input  logic                    rst,
  acl_spi_reader_if.master        spi,
  output logic [9:0]              acl_out,
  output logic                    acl_valid,
  output logic                    init_done
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW  = $clog2(2 * CLK_DIV);
  localparam int unsigned SampW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [7:0]  RdCmd = 8'hC0 | {2'b00, AXIS_REG[5:0]};

  typedef enum logic [2:0] {
    StInit, StInitGap, StIdle, StRdCmd, StRdData, StDone
  } state_e;

  state_e           state_q;
  logic [DivW-1:0]  div_q;
  logic [5:0]       hcnt_q;
  logic [23:0]      tx_q;
  logic [15:0]      rx_q;
  logic [GapW-1:0]  gap_q;
  logic [SampW-1:0] samp_q;
  logic             pend_q;
  logic             sclk_q, mosi_q, cs_n_q;
  logic [9:0]       out_q;
  logic             valid_q, init_done_q;

  logic       tick, ev_fall, ev_rise, ev_end;
  logic       samp_tick, gap_ok, start_rd;
  logic [5:0] hcnt_last;
  logic [9:0] raw, sample;

  // hcnt counts half-period events: even = SCLK fall, odd = SCLK rise, last = CS release.
  assign tick      = !cs_n_q && (div_q == DivW'(CLK_DIV - 1));
  assign hcnt_last = (state_q == StInit) ? 6'd32 : 6'd48;
  assign ev_end    = tick && (hcnt_q == hcnt_last);
  assign ev_fall   = tick && !ev_end && !hcnt_q[0];
  assign ev_rise   = tick && hcnt_q[0];
  assign samp_tick = init_done_q && (samp_q == SampW'(SAMPLE_PERIOD - 1));
  assign gap_ok    = (gap_q == GapW'(2 * CLK_DIV - 1));
  assign start_rd  = (state_q == StIdle) && (pend_q || samp_tick) && gap_ok;

  // First received byte (low) lands in rx_q[15:8], the high byte in rx_q[7:0].
  assign raw = {rx_q[1:0], rx_q[15:8]};

`ifdef ACL_AVG_EN
  logic [9:0] hist1_q, hist2_q, hist3_q;

  assign sample = 10'(($signed({{2{raw[9]}}, raw})         + $signed({{2{hist1_q[9]}}, hist1_q})
                     + $signed({{2{hist2_q[9]}}, hist2_q}) + $signed({{2{hist3_q[9]}}, hist3_q}))
                     >>> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist1_q <= '0;
      hist2_q <= '0;
      hist3_q <= '0;
    end else if (state_q == StDone) begin
      hist1_q <= raw;
      hist2_q <= hist1_q;
      hist3_q <= hist2_q;
    end
  end
`else
  assign sample = raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      div_q       <= '0;
      hcnt_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      gap_q       <= '0;
      samp_q      <= '0;
      pend_q      <= 1'b0;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      out_q       <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      div_q   <= (cs_n_q || tick) ? '0 : div_q + DivW'(1);

      if (!cs_n_q)     gap_q <= '0;
      else if (!gap_ok) gap_q <= gap_q + GapW'(1);

      if (init_done_q) samp_q <= samp_tick ? '0 : samp_q + SampW'(1);
      pend_q <= (pend_q || samp_tick) && !start_rd;

      if (ev_fall) begin
        sclk_q <= 1'b0;
        mosi_q <= tx_q[23];
        tx_q   <= {tx_q[22:0], 1'b0};
        hcnt_q <= hcnt_q + 6'd1;
      end
      if (ev_rise) begin
        sclk_q <= 1'b1;
        hcnt_q <= hcnt_q + 6'd1;
        if (state_q == StRdData) rx_q <= {rx_q[14:0], spi.acl_miso};
      end
      if (ev_end) begin
        cs_n_q <= 1'b1;
        mosi_q <= 1'b0;
      end

      case (state_q)
        StInit: begin
          if (cs_n_q) begin
            cs_n_q <= 1'b0;
            hcnt_q <= '0;
            tx_q   <= {16'h2D08, 8'h00};
          end else if (ev_end) begin
            init_done_q <= 1'b1;
            state_q     <= StInitGap;
          end
        end
        StInitGap: if (gap_ok) state_q <= StIdle;
        StIdle: begin
          if (start_rd) begin
            cs_n_q  <= 1'b0;
            hcnt_q  <= '0;
            tx_q    <= {RdCmd, 16'h0000};
            state_q <= StRdCmd;
          end
        end
        StRdCmd:  if (ev_rise && hcnt_q == 6'd15) state_q <= StRdData;
        StRdData: if (ev_end) state_q <= StDone;
        StDone: begin
          out_q   <= sample;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign spi.acl_sclk = sclk_q;
  assign spi.acl_mosi = mosi_q;
  assign spi.acl_cs_n = cs_n_q;
  assign acl_out      = out_q;
  assign acl_valid    = valid_q;
  assign init_done    = init_done_q;

endmodule
